// File: rtl/demux_1in_3out_reg_if.sv
// Handshake bundle for demux_1in_3out_reg: one producer port and three consumer ports.
// The demux takes the slave view and the producer/consumer side takes the master view.
interface demux_1in_3out_reg_if #(
    parameter int DB = 32
);
    logic [DB-1:0] DatoIn;
    logic [1:0]    Sel;
    logic          in_valid;
    logic          in_ready;

    logic [DB-1:0] SalidaA;
    logic [DB-1:0] SalidaB;
    logic [DB-1:0] SalidaC;
    logic          valid_a;
    logic          valid_b;
    logic          valid_c;
    logic          ready_a;
    logic          ready_b;
    logic          ready_c;

    modport slave (
        input  DatoIn, Sel, in_valid, ready_a, ready_b, ready_c,
        output in_ready, SalidaA, SalidaB, SalidaC, valid_a, valid_b, valid_c
    );

    modport master (
        output DatoIn, Sel, in_valid, ready_a, ready_b, ready_c,
        input  in_ready, SalidaA, SalidaB, SalidaC, valid_a, valid_b, valid_c
    );
endinterface

// File: rtl/demux_1in_3out_reg.sv
// Registered 1-to-3 demux: steers DatoIn to A/B/C by Sel; Sel=3 is dropped and counted (broadcast with DEMUX_BROADCAST_EN).
// Latency: one clock, word accepted at edge N is valid in cycle N+1; sustained throughput 1 word/clk.
// Backpressure: in_ready is low while any pending destination is not ready; held words stay stable until taken.
module demux_1in_3out_reg #(
    parameter int DB = 32,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1in_3out_reg_if.slave  bus,
    output logic [CW-1:0]        drop_count
);
    logic [DB-1:0] holdData;
    logic [2:0]    pend;
    logic [2:0]    pendNext;
    logic [2:0]    readyVec;
    logic [2:0]    remain;
    logic [CW-1:0] dropCnt;
    logic [CW-1:0] dropNext;
    logic          done;
    logic          accept;
    logic          loadData;

    // Ready on a destination with nothing pending is simply masked away here.
    assign readyVec = {bus.ready_c, bus.ready_b, bus.ready_a};
    assign remain   = pend & ~readyVec;
    assign done     = (remain == 3'b000);
    assign accept   = bus.in_valid & done;

    always_comb begin
        pendNext = remain;
        loadData = 1'b0;
        dropNext = dropCnt;
        if (accept) begin
            case (bus.Sel)
                2'd0: begin pendNext = 3'b001; loadData = 1'b1; end
                2'd1: begin pendNext = 3'b010; loadData = 1'b1; end
                2'd2: begin pendNext = 3'b100; loadData = 1'b1; end
                default: begin
`ifdef DEMUX_BROADCAST_EN
                    pendNext = 3'b111;
                    loadData = 1'b1;
`else
                    pendNext = 3'b000;
                    if (dropCnt != {CW{1'b1}}) begin
                        dropNext = dropCnt + CW'(1);
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 3'b000;
            holdData <= '0;
            dropCnt  <= '0;
        end else begin
            pend    <= pendNext;
            dropCnt <= dropNext;
            if (loadData) begin
                holdData <= bus.DatoIn;
            end
        end
    end

    assign bus.in_ready = done;
    assign bus.valid_a  = pend[0];
    assign bus.valid_b  = pend[1];
    assign bus.valid_c  = pend[2];
    assign bus.SalidaA  = pend[0] ? holdData : '0;
    assign bus.SalidaB  = pend[1] ? holdData : '0;
    assign bus.SalidaC  = pend[2] ? holdData : '0;
    assign drop_count   = dropCnt;
endmodule
